pixel_shuffle_in_packer: RTL and testbench
==========================================

PIXEL_SHUFFLE_IN_PACKER -- requirements
Module: pixel_shuffle_in_packer

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- C, 1, output channels of the downstream pixel_shuffle.
- R, 2, upscale factor.
- H, 2, input tile height.
- W, 2, input tile width.
- DATA_WIDTH, 8, bits per pixel.
- Derived N = C*R*R*H*W, the pixels per frame.
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock, rising edge.
- rst, in, 1, asynchronous active-high reset.
- s_valid, in, 1, upstream pixel valid.
- s_ready, out, 1, block can accept a pixel.
- s_data, in, DATA_WIDTH, pixel in channel-major, row-major order.
- s_last, in, 1, marks the final pixel of a frame.
- ps_start, out, 1, one-cycle launch pulse to pixel_shuffle.
- ps_in_data_flat, out, N*DATA_WIDTH, packed frame; pixel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- ps_done, in, 1, pixel_shuffle completion.
- len_err, out, 1, one-cycle pulse when the frame length mismatches s_last.
- frame_cnt, out, 16, count of frames launched.

Function
REQ-003 The block SHALL implement an FSM with states FILL, LAUNCH and WAIT.
REQ-004 In FILL, s_ready SHALL be 1, and a handshake (s_valid & s_ready) SHALL write s_data into slot cnt and increment cnt.
REQ-005 A handshake with cnt==N-1, or with s_last=1, SHALL move the FSM to LAUNCH on the next edge.
REQ-006 On an early s_last (cnt<N-1), slots cnt+1..N-1 SHALL read as 0, and len_err SHALL pulse in the following cycle.
REQ-007 On a handshake at cnt==N-1 with s_last=0, the frame SHALL still launch, and len_err SHALL pulse in the following cycle.
REQ-008 In LAUNCH, ps_start SHALL be 1 for exactly one cycle, frame_cnt SHALL increment (wrapping 0xFFFF to 0), and the next state SHALL be WAIT.
REQ-009 Latency: if the last pixel handshakes in cycle t, ps_start SHALL be high in cycle t+1.
REQ-010 In LAUNCH and WAIT, s_ready SHALL be 0, and ps_in_data_flat SHALL be held constant.
REQ-011 In WAIT, ps_done=1 SHALL move the FSM to FILL with cnt=0 and all slots cleared to 0, so s_ready is 1 in the next cycle.
REQ-012 ps_done SHALL be ignored in FILL and in LAUNCH.
REQ-013 s_data and s_last SHALL be ignored whenever s_valid=0 or s_ready=0.
REQ-014 cnt SHALL be $clog2(N)+1 bits wide and SHALL never exceed N-1.

Reset
REQ-015 Asserting rst SHALL immediately force:
- FSM to FILL;
- cnt=0;
- all slots, and therefore ps_in_data_flat, to 0;
- ps_start=0, len_err=0, frame_cnt=0;
- s_ready=1 once rst is released.
REQ-016 A reset mid-frame or in WAIT SHALL discard the partial frame, with no ps_start issued.

Configuration
REQ-017 When macro PIXEL_SHUFFLE_IN_PACKER_RELU_EN is defined, s_data SHALL be treated as two's complement, and any pixel with MSB=1 SHALL be stored as 0.
REQ-018 Without that macro, s_data SHALL be stored verbatim.

Verification
REQ-019 Full frame (C=1,R=2,H=2,W=2, N=16): stream values 1..16 back-to-back, with s_last on 16 -> ps_start one cycle after pixel 16; ps_in_data_flat bytes 0..15 = 1..16; frame_cnt=1; len_err stays 0.
REQ-020 Backpressure: after the launch, hold s_valid=1 and delay ps_done by 20 cycles -> s_ready=0 throughout WAIT and data stable; s_ready=1 the cycle after ps_done.
REQ-021 Early s_last on pixel 10 (values 1..10) -> ps_start next cycle; bytes 10..15 = 0; len_err pulses once.
REQ-022 Missing s_last on pixel 16 -> frame launches normally; len_err pulses once; frame_cnt increments.
REQ-023 Assert rst after 7 pixels, then send a clean frame 101..116 -> no ps_start before the new frame; output bytes = 101..116; frame_cnt=1.
REQ-024 With PIXEL_SHUFFLE_IN_PACKER_RELU_EN defined, send 0x80 and 0x7F -> stored as 0x00 and 0x7F respectively; without the macro -> stored as 0x80 and 0x7F.

Source files
------------

// File: rtl/pixel_shuffle_in_packer.sv
// Collects one frame of pixels into a flat register and hands it to pixel_shuffle.
// Optional macro PIXEL_SHUFFLE_IN_PACKER_RELU_EN clamps negative two's-complement pixels to zero.
module pixel_shuffle_in_packer #(
    parameter  int C          = 1,
    parameter  int R          = 2,
    parameter  int H          = 2,
    parameter  int W          = 2,
    parameter  int DATA_WIDTH = 8,
    localparam int N          = C * R * R * H * W,
    localparam int CW         = $clog2(N) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [DATA_WIDTH-1:0]   s_data,
    input  logic                    s_last,
    output logic                    ps_start,
    output logic [N*DATA_WIDTH-1:0] ps_in_data_flat,
    input  logic                    ps_done,
    output logic                    len_err,
    output logic [15:0]             frame_cnt
);

    typedef enum logic [1:0] {FILL, LAUNCH, WAIT} state_t;

    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [N*DATA_WIDTH-1:0] data_q, data_d;
    logic                    len_err_q, len_err_d;
    logic [15:0]             frame_cnt_q, frame_cnt_d;
    logic                    hs;

    function automatic logic [DATA_WIDTH-1:0] relu_clamp(input logic signed [DATA_WIDTH-1:0] v);
`ifdef PIXEL_SHUFFLE_IN_PACKER_RELU_EN
        return (v < 0) ? '0 : $unsigned(v);
`else
        return $unsigned(v);
`endif
    endfunction

    assign s_ready         = (state_q == FILL);
    assign ps_start        = (state_q == LAUNCH);
    assign hs              = s_valid && s_ready;
    assign ps_in_data_flat = data_q;
    assign len_err         = len_err_q;
    assign frame_cnt       = frame_cnt_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        len_err_d   = 1'b0;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            FILL: begin
                if (hs) begin
                    for (int k = 0; k < N; k++) begin
                        if (cnt_q == CW'(k)) begin
                            data_d[k*DATA_WIDTH +: DATA_WIDTH] = relu_clamp(s_data);
                        end
                    end
                    // cnt parks on the final slot while the frame is out; ps_done rewinds it
                    if ((cnt_q == LAST_IDX) || s_last) begin
                        state_d   = LAUNCH;
                        len_err_d = (cnt_q == LAST_IDX) != s_last;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            LAUNCH: begin
                frame_cnt_d = frame_cnt_q + 16'd1;
                state_d     = WAIT;
            end
            WAIT: begin
                if (ps_done) begin
                    state_d = FILL;
                    cnt_d   = '0;
                    data_d  = '0;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FILL;
            cnt_q       <= '0;
            data_q      <= '0;
            len_err_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            len_err_q   <= len_err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

endmodule

// File: tb/tb_pixel_shuffle_in_packer.sv
// Scoreboard bench for pixel_shuffle_in_packer: directed frames, launch monitor checks packed data.
module tb_pixel_shuffle_in_packer;

    localparam int N  = 16;
    localparam int DW = 8;
    localparam int NB = N * DW;

    typedef struct {
        logic [NB-1:0] data;
        logic          lerr;
        logic [15:0]   fcnt;
        int            cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          s_last = 1'b0;
    logic          ps_start;
    logic [NB-1:0] ps_in_data_flat;
    logic          ps_done = 1'b0;
    logic          len_err;
    logic [15:0]   frame_cnt;

    exp_t          sb[$];
    int            n_cmp = 0;
    int            n_err = 0;
    int            cyc = 0;
    int            lerr_seen = 0;
    int            idx = 0;
    logic [NB-1:0] exp_flat = '0;
    logic [NB-1:0] last_flat = '0;
    logic [15:0]   model_fcnt = '0;

    pixel_shuffle_in_packer dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_last(s_last), .ps_start(ps_start), .ps_in_data_flat(ps_in_data_flat),
        .ps_done(ps_done), .len_err(len_err), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [NB-1:0] act, input logic [NB-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every launch pops the next expected frame.
    always @(negedge clk) begin
        if (!rst && len_err) lerr_seen++;
        if (!rst && ps_start) begin
            if (sb.size() == 0) begin
                chk("unexpected_ps_start", 1'b1, 1'b0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("frame_data", ps_in_data_flat, e.data);
                chk("len_err_at_launch", len_err, e.lerr);
                chk("frame_cnt_at_launch", frame_cnt, e.fcnt);
                chk("launch_latency_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic send_px(input logic [DW-1:0] v, input logic [DW-1:0] stored, input logic last);
        exp_t e;
        s_valid = 1'b1;
        s_data  = v;
        s_last  = last;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        exp_flat[idx*DW +: DW] = stored;
        if (last || idx == N - 1) begin
            e.data = exp_flat;
            e.lerr = (idx == N - 1) != last;
            e.fcnt = model_fcnt;
            e.cyc  = cyc;
            sb.push_back(e);
            model_fcnt = model_fcnt + 16'd1;
            last_flat  = exp_flat;
            exp_flat   = '0;
            idx        = 0;
        end else begin
            idx++;
        end
    endtask

    task automatic finish_frame(input int dly, input logic hold_valid);
        int  n;
        bit  seen;
        seen = 0;
        n = 0;
        while (!seen && n < 10) begin
            @(negedge clk);
            if (ps_start) seen = 1;
            n++;
        end
        if (!seen) chk("ps_start_timeout", 1'b0, 1'b1);
        for (int i = 0; i < dly; i++) begin
            @(posedge clk);
            #1;
            if (hold_valid) begin
                s_valid = 1'b1;
                s_data  = DW'($urandom);
            end
            @(negedge clk);
            chk("s_ready_in_wait", s_ready, 1'b0);
            chk("data_stable_in_wait", ps_in_data_flat, last_flat);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        ps_done = 1'b1;
        @(posedge clk);
        #1;
        ps_done = 1'b0;
        @(negedge clk);
        chk("s_ready_after_done", s_ready, 1'b1);
        chk("slots_cleared_after_done", ps_in_data_flat, '0);
        chk("frame_cnt_after_frame", frame_cnt, model_fcnt);
    endtask

    initial begin
        logic [DW-1:0] neg_exp;
        #1 rst = 1'b1;
        #2;
        chk("reset_s_ready", s_ready, 1'b1);
        chk("reset_ps_start", ps_start, 1'b0);
        chk("reset_len_err", len_err, 1'b0);
        chk("reset_frame_cnt", frame_cnt, '0);
        chk("reset_data", ps_in_data_flat, '0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Full frame 1..16, held s_valid while waiting 20 cycles for ps_done
        for (int k = 1; k <= 16; k++) send_px(DW'(k), DW'(k), k == 16);
        finish_frame(20, 1'b1);

        // Early s_last on pixel 10; ps_done pulse in FILL must be ignored
        for (int k = 1; k <= 10; k++) begin
            if (k == 5) ps_done = 1'b1;
            send_px(DW'(k), DW'(k), k == 10);
            ps_done = 1'b0;
        end
        finish_frame(3, 1'b0);

        // Missing s_last on pixel 16
        for (int k = 0; k < 16; k++) send_px(DW'(8'h21 + k), DW'(8'h21 + k), 1'b0);
        finish_frame(2, 1'b0);

        // Reset after 7 pixels, partial frame discarded
        for (int k = 0; k < 7; k++) send_px(DW'(8'h50 + k), DW'(8'h50 + k), 1'b0);
        rst = 1'b1;
        #1;
        chk("midframe_reset_data", ps_in_data_flat, '0);
        chk("midframe_reset_frame_cnt", frame_cnt, '0);
        chk("midframe_reset_ps_start", ps_start, 1'b0);
        idx = 0;
        exp_flat = '0;
        model_fcnt = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("s_ready_after_reset", s_ready, 1'b1);
        for (int k = 101; k <= 116; k++) send_px(DW'(k), DW'(k), k == 116);
        finish_frame(2, 1'b0);

        // Negative pixel handling
`ifdef PIXEL_SHUFFLE_IN_PACKER_RELU_EN
        neg_exp = 8'h00;
`else
        neg_exp = 8'h80;
`endif
        send_px(8'h80, neg_exp, 1'b0);
        send_px(8'h7F, 8'h7F, 1'b1);
        finish_frame(2, 1'b0);

        repeat (3) @(negedge clk);
        chk("len_err_pulse_count", lerr_seen, 3);
        chk("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
